prog_sequencer: RTL

Parametrised successor to the single-cycle core's ad-hoc Start/Ack gating and free-running cycle counter. It sequences a batch of NPROG programs held in one instruction ROM, supplies the program counter with a per-program base address, and gates core execution. It measures per-program cycle counts and enforces an optional watchdog timeout. It sits between the testbench handshake (Start/Ack) and the core's ProgCtr/Ctrl blocks, replacing the `ever_start` / `should_run_processor` logic.

---
 rtl/prog_seq_pkg.sv | 11 +
 rtl/sat_counter.sv | 28 ++
 rtl/prog_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/prog_seq_pkg.sv
// Shared types and helpers for the program sequencer.
package prog_seq_pkg;

    typedef enum logic [2:0] {IDLE, ARMED, RUN, DONE, TOUT} seq_state_t;

    // Index width that never collapses to zero for single-program batches.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : int'($clog2(n));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and saturation at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/prog_sequencer.sv
// Batch program sequencer: Start/Ack handshake, PC base loading, run gating,
// per-program cycle counting and optional watchdog.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned NPROG   = 3,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned MAX_CYC = 0
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic [NPROG*PC_W-1:0]    ProgBase,
    input  logic                     Halt,
    output logic                     Run,
    output logic                     PcLoad,
    output logic [PC_W-1:0]          PcLoadAddr,
    output logic                     Ack,
    output logic                     Timeout,
    output logic [idx_w(NPROG)-1:0]  ProgIdx,
    output logic [CNT_W-1:0]         CycleCount
);

    localparam int unsigned       IW      = idx_w(NPROG);
    localparam logic [IW-1:0]     LastIdx = IW'(NPROG - 1);
    // Only meaningful when MAX_CYC != 0; wd_hit is gated accordingly.
    localparam logic [CNT_W-1:0]  WdLast  = CNT_W'(MAX_CYC - 1);

    seq_state_t    state_q, state_d;
    logic [IW-1:0] prog_idx_q, prog_idx_d;
    logic          timeout_q, timeout_d;
    logic          wd_hit;
    logic          cnt_clr;
    logic [31:0]   base_sel;

    assign wd_hit = (MAX_CYC != 0) && (CycleCount == WdLast);

    // Priority in RUN: Start (abort) over Halt over watchdog.
    always_comb begin
        state_d    = state_q;
        prog_idx_d = prog_idx_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (Start) state_d = ARMED;
            end
            ARMED: begin
                if (!Start) begin
                    state_d   = RUN;
                    timeout_d = 1'b0;
                end
            end
            RUN: begin
                if (Start) begin
                    state_d = ARMED;
                end else if (Halt) begin
                    state_d = DONE;
                end else if (wd_hit) begin
                    state_d   = TOUT;
                    timeout_d = 1'b1;
                end
            end
            DONE, TOUT: begin
                if (Start) begin
                    state_d    = ARMED;
                    prog_idx_d = (prog_idx_q == LastIdx) ? '0 : prog_idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= IDLE;
            prog_idx_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            prog_idx_q <= prog_idx_d;
            timeout_q  <= timeout_d;
        end
    end

    // Clearing on ARMED entry keeps the count at 0 for the whole ARMED dwell.
    assign cnt_clr = Reset || (state_d == ARMED);

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk_i (Clk),
        .clr_i (cnt_clr),
        .en_i  (state_q == RUN),
        .cnt_o (CycleCount)
    );

    assign base_sel   = 32'(prog_idx_q) * PC_W;
    assign Run        = (state_q == RUN);
    assign PcLoad     = (state_q == ARMED);
    assign PcLoadAddr = PcLoad ? ProgBase[base_sel +: PC_W] : '0;
    assign Ack        = (state_q == DONE) || (state_q == TOUT);
    assign Timeout    = timeout_q;
    assign ProgIdx    = prog_idx_q;

endmodule
